seg7_scan_driver: RTL and testbench

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

---
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment scan driver with double-buffered value load and leading-zero blanking.
// Optional blink feature is enabled by defining SEG7_BLINK_EN.
module seg7_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLINK_DIV  = 256
) (
    input  logic                    iCLK,
    input  logic                    iRST_N,
    input  logic [4*NUM_DIGITS-1:0] iVALUE,
    input  logic                    iLOAD,
    input  logic [NUM_DIGITS-1:0]   iDP,
    input  logic                    iBLANK_LZ,
    input  logic [NUM_DIGITS-1:0]   iBLINK,
    output logic [6:0]              oSEG,
    output logic                    oSEG_DP,
    output logic [NUM_DIGITS-1:0]   oDIG_SEL,
    output logic                    oFRAME,
    output logic                    oPENDING
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRE_PENULT = PW'(SCAN_DIV - 2);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

    logic [PW-1:0]           r_prescale;
    logic [IW-1:0]           r_index;
    logic                    r_frame;
    logic [4*NUM_DIGITS-1:0] r_disp;
    logic [NUM_DIGITS-1:0]   r_disp_dp;
    logic [4*NUM_DIGITS-1:0] r_pend;
    logic [NUM_DIGITS-1:0]   r_pend_dp;
    logic                    r_pending;
    logic [6:0]              r_seg;
    logic                    r_seg_dp;
    logic [NUM_DIGITS-1:0]   r_dig_sel;

    logic                    w_wrap;
    logic                    w_last;
    logic                    w_boundary;
    logic [3:0]              w_nib;
    logic                    w_dp;
    logic                    w_blink;
    logic                    w_blank;
    logic [NUM_DIGITS-1:0]   w_sel;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;

    function automatic logic [6:0] f_encode(input logic [3:0] nib);
        case (nib)
            4'h0: f_encode = 7'b1000000;
            4'h1: f_encode = 7'b1111001;
            4'h2: f_encode = 7'b0100100;
            4'h3: f_encode = 7'b0110000;
            4'h4: f_encode = 7'b0011001;
            4'h5: f_encode = 7'b0010010;
            4'h6: f_encode = 7'b0000010;
            4'h7: f_encode = 7'b1111000;
            4'h8: f_encode = 7'b0000000;
            4'h9: f_encode = 7'b0011000;
            4'hA: f_encode = 7'b0001000;
            4'hB: f_encode = 7'b0000011;
            4'hC: f_encode = 7'b1000110;
            4'hD: f_encode = 7'b0100001;
            4'hE: f_encode = 7'b0000110;
            default: f_encode = 7'b0001110;
        endcase
    endfunction

    assign w_wrap     = (r_prescale == PRE_LAST);
    assign w_last     = (r_index == IDX_LAST);
    assign w_boundary = w_wrap && w_last;

    // A digit blanks when it and every more-significant nibble are zero; digit 0 is exempt.
    always_comb begin
        w_nib   = 4'h0;
        w_dp    = 1'b0;
        w_blink = 1'b0;
        w_sel   = '1;
        w_blank = iBLANK_LZ && (r_index != '0);
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k == int'(r_index)) begin
                w_nib    = r_disp[4*k +: 4];
                w_dp     = r_disp_dp[k];
                w_blink  = iBLINK[k];
                w_sel[k] = 1'b0;
            end
            if ((k >= int'(r_index)) && (r_disp[4*k +: 4] != 4'h0)) begin
                w_blank = 1'b0;
            end
        end
    end

`ifdef SEG7_BLINK_EN
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_hidden;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_blink_cnt <= '0;
            r_hidden    <= 1'b0;
        end else if (w_boundary) begin
            if (r_blink_cnt == BLINK_LAST) begin
                r_blink_cnt <= '0;
                r_hidden    <= ~r_hidden;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_seg_next = w_blank ? 7'h7F : f_encode(w_nib);
        w_dp_next  = ~w_dp;
        if (r_hidden && w_blink) begin
            w_seg_next = 7'h7F;
            w_dp_next  = 1'b1;
        end
    end
`else
    logic w_unused_blink;
    assign w_unused_blink = w_blink ^ (BLINK_DIV > 0);

    always_comb begin
        w_seg_next = w_blank ? 7'h7F : f_encode(w_nib);
        w_dp_next  = ~w_dp;
    end
`endif

    // oFRAME is pre-decoded one cycle early so it is registered yet aligned with the boundary cycle.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            r_prescale <= '0;
            r_index    <= '0;
            r_frame    <= 1'b0;
            r_disp     <= '0;
            r_disp_dp  <= '0;
            r_pend     <= '0;
            r_pend_dp  <= '0;
            r_pending  <= 1'b0;
            r_seg      <= 7'h7F;
            r_seg_dp   <= 1'b1;
            r_dig_sel  <= '1;
        end else begin
            r_prescale <= w_wrap ? '0 : r_prescale + 1'b1;
            if (w_wrap) begin
                r_index <= w_last ? '0 : r_index + 1'b1;
            end
            r_frame <= (r_prescale == PRE_PENULT) && w_last;
            if (w_boundary && r_pending) begin
                r_disp    <= r_pend;
                r_disp_dp <= r_pend_dp;
            end
            if (iLOAD) begin
                r_pend    <= iVALUE;
                r_pend_dp <= iDP;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
            r_seg     <= w_seg_next;
            r_seg_dp  <= w_dp_next;
            r_dig_sel <= w_sel;
        end
    end

    assign oSEG     = r_seg;
    assign oSEG_DP  = r_seg_dp;
    assign oDIG_SEL = r_dig_sel;
    assign oFRAME   = r_frame;
    assign oPENDING = r_pending;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver against a cycle-count based reference model.
// Blink expectations follow SEG7_BLINK_EN when it is defined for the build.
module tb_seg7_scan_driver;

    localparam int N = 4;
    localparam int S = 4;
    localparam int B = 2;
    localparam int F = N * S;

    logic          iCLK = 1'b0;
    logic          iRST_N = 1'b0;
    logic [15:0]   iVALUE = '0;
    logic          iLOAD = 1'b0;
    logic [3:0]    iDP = '0;
    logic          iBLANK_LZ = 1'b0;
    logic [3:0]    iBLINK = '0;
    logic [6:0]    oSEG;
    logic          oSEG_DP;
    logic [3:0]    oDIG_SEL;
    logic          oFRAME;
    logic          oPENDING;

    int checks = 0;
    int failures = 0;

    // Reference model: edges since reset release plus the two value registers.
    int          n;
    logic [15:0] m_disp, m_pend;
    logic [3:0]  m_disp_dp, m_pend_dp;
    logic        m_pending;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic [3:0]  exp_sel;
    logic        exp_frame;
    logic        exp_pending;

    seg7_scan_driver #(.NUM_DIGITS(N), .SCAN_DIV(S), .BLINK_DIV(B)) dut (
        .iCLK(iCLK), .iRST_N(iRST_N), .iVALUE(iVALUE), .iLOAD(iLOAD), .iDP(iDP),
        .iBLANK_LZ(iBLANK_LZ), .iBLINK(iBLINK), .oSEG(oSEG), .oSEG_DP(oSEG_DP),
        .oDIG_SEL(oDIG_SEL), .oFRAME(oFRAME), .oPENDING(oPENDING)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [6:0] encode(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;  4'h9: return 7'b0011000;
            4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    task automatic model_clear();
        n = 0;
        m_disp = '0; m_pend = '0; m_disp_dp = '0; m_pend_dp = '0; m_pending = 1'b0;
    endtask

    // Advance one clock edge, then derive the expected outputs from the scan arithmetic.
    task automatic tick();
        int  d, fr;
        logic blank, boundary_edge;
        @(posedge iCLK); #1;
        n++;
        d  = ((n - 1) / S) % N;
        fr = (n - 1) / F;
        blank = iBLANK_LZ && (d > 0);
        for (int k = d; k < N; k++) if (m_disp[4*k +: 4] != 4'h0) blank = 1'b0;
        exp_seg = blank ? 7'h7F : encode(m_disp[4*d +: 4]);
        exp_dp  = ~m_disp_dp[d];
        exp_sel = ~(4'b0001 << d);
`ifdef SEG7_BLINK_EN
        if (((fr / B) % 2 == 1) && iBLINK[d]) begin
            exp_seg = 7'h7F;
            exp_dp  = 1'b1;
        end
`else
        if (fr < 0) exp_dp = 1'bx;
`endif
        boundary_edge = ((n - 1) % F == F - 1);
        if (boundary_edge && m_pending) begin
            m_disp = m_pend; m_disp_dp = m_pend_dp;
        end
        if (iLOAD) begin
            m_pend = iVALUE; m_pend_dp = iDP; m_pending = 1'b1;
        end else if (boundary_edge) begin
            m_pending = 1'b0;
        end
        exp_frame   = (n % F == F - 1);
        exp_pending = m_pending;
    endtask

    task automatic apply_reset();
        @(posedge iCLK); #1;
        iRST_N = 1'b0; iLOAD = 1'b0;
        repeat (2) @(posedge iCLK);
        #1;
        iRST_N = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        @(posedge iCLK); #1;
        iRST_N = 1'b0;
        #2;
        checks++; if (oSEG !== 7'h7F) begin failures++; $display("[TB] FAIL reset_seg got=%b exp=%b", oSEG, 7'h7F); end
        checks++; if (oSEG_DP !== 1'b1) begin failures++; $display("[TB] FAIL reset_dp got=%b exp=1", oSEG_DP); end
        checks++; if (oDIG_SEL !== 4'b1111) begin failures++; $display("[TB] FAIL reset_sel got=%b exp=1111", oDIG_SEL); end
        checks++; if (oFRAME !== 1'b0) begin failures++; $display("[TB] FAIL reset_frame got=%b exp=0", oFRAME); end
        checks++; if (oPENDING !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending got=%b exp=0", oPENDING); end
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        model_clear();
        tick();
        checks++; if (oDIG_SEL !== 4'b1110) begin failures++; $display("[TB] FAIL first_sel got=%b exp=1110", oDIG_SEL); end
        checks++; if (oSEG !== 7'b1000000) begin failures++; $display("[TB] FAIL first_seg got=%b exp=1000000", oSEG); end
    endtask

    task automatic test_scan();
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            checks++; if (oDIG_SEL !== exp_sel) begin failures++; $display("[TB] FAIL scan_sel n=%0d got=%b exp=%b", n, oDIG_SEL, exp_sel); end
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL scan_seg n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oFRAME !== exp_frame) begin failures++; $display("[TB] FAIL scan_frame n=%0d got=%b exp=%b", n, oFRAME, exp_frame); end
        end
    endtask

    task automatic test_load_mid();
        repeat (5) tick();
        iVALUE = 16'h12AF; iDP = 4'b0000; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        checks++; if (oPENDING !== 1'b1) begin failures++; $display("[TB] FAIL load_pending got=%b exp=1", oPENDING); end
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL load_seg n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oPENDING !== exp_pending) begin failures++; $display("[TB] FAIL load_pend n=%0d got=%b exp=%b", n, oPENDING, exp_pending); end
        end
    endtask

    task automatic test_blank_lz();
        iVALUE = 16'h0050; iBLANK_LZ = 1'b1; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        for (int i = 0; i < 4 * F; i++) begin
            if (i == 2 * F) iBLANK_LZ = 1'b0;
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL blank_seg n=%0d lz=%b got=%b exp=%b", n, iBLANK_LZ, oSEG, exp_seg); end
        end
    endtask

    task automatic test_boundary_load();
        bit found = 1'b0;
        for (int i = 0; i < 2 * F && !found; i++) begin
            tick();
            if (oFRAME === 1'b1) found = 1'b1;
        end
        checks++; if (!found) begin failures++; $display("[TB] FAIL boundary_wait got=no_frame exp=frame_within_%0d", 2 * F); end
        iVALUE = 16'h9999; iDP = 4'b0000; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        checks++; if (oPENDING !== 1'b1) begin failures++; $display("[TB] FAIL boundary_pending got=%b exp=1", oPENDING); end
        for (int i = 0; i < 2 * F; i++) begin
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL boundary_seg n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oPENDING !== exp_pending) begin failures++; $display("[TB] FAIL boundary_pend n=%0d got=%b exp=%b", n, oPENDING, exp_pending); end
        end
    endtask

    task automatic test_dp();
        iVALUE = 16'h4321; iDP = 4'b0100; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        for (int i = 0; i < 3 * F; i++) begin
            tick();
            checks++; if (oSEG_DP !== exp_dp) begin failures++; $display("[TB] FAIL dp n=%0d sel=%b got=%b exp=%b", n, oDIG_SEL, oSEG_DP, exp_dp); end
            checks++; if (oDIG_SEL !== exp_sel) begin failures++; $display("[TB] FAIL dp_sel n=%0d got=%b exp=%b", n, oDIG_SEL, exp_sel); end
        end
    endtask

    task automatic test_blink();
        apply_reset();
        iVALUE = 16'h8421; iDP = 4'b0001; iBLINK = 4'b0001; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        for (int i = 1; i < 6 * F; i++) begin
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL blink_seg n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oSEG_DP !== exp_dp) begin failures++; $display("[TB] FAIL blink_dp n=%0d got=%b exp=%b", n, oSEG_DP, exp_dp); end
        end
        iBLINK = 4'b0000;
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            iLOAD = ($urandom_range(0, 9) == 0);
            iVALUE = 16'($urandom);
            if ($urandom_range(0, 2) == 0) iVALUE = iVALUE & 16'h00FF;
            iDP = 4'($urandom);
            if ($urandom_range(0, 15) == 0) iBLANK_LZ = ~iBLANK_LZ;
            if ($urandom_range(0, 31) == 0) iBLINK = 4'($urandom);
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL rand_seg n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oSEG_DP !== exp_dp) begin failures++; $display("[TB] FAIL rand_dp n=%0d got=%b exp=%b", n, oSEG_DP, exp_dp); end
            checks++; if (oDIG_SEL !== exp_sel) begin failures++; $display("[TB] FAIL rand_sel n=%0d got=%b exp=%b", n, oDIG_SEL, exp_sel); end
            checks++; if (oFRAME !== exp_frame) begin failures++; $display("[TB] FAIL rand_frame n=%0d got=%b exp=%b", n, oFRAME, exp_frame); end
            checks++; if (oPENDING !== exp_pending) begin failures++; $display("[TB] FAIL rand_pend n=%0d got=%b exp=%b", n, oPENDING, exp_pending); end
        end
        iLOAD = 1'b0;
    endtask

    task automatic test_reset_mid();
        iVALUE = 16'hFEDC; iDP = 4'b1111; iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        repeat (3) tick();
        iRST_N = 1'b0;
        #1;
        checks++; if (oSEG !== 7'h7F) begin failures++; $display("[TB] FAIL midrst_seg got=%b exp=%b", oSEG, 7'h7F); end
        checks++; if (oSEG_DP !== 1'b1) begin failures++; $display("[TB] FAIL midrst_dp got=%b exp=1", oSEG_DP); end
        checks++; if (oDIG_SEL !== 4'b1111) begin failures++; $display("[TB] FAIL midrst_sel got=%b exp=1111", oDIG_SEL); end
        checks++; if (oPENDING !== 1'b0) begin failures++; $display("[TB] FAIL midrst_pending got=%b exp=0", oPENDING); end
        @(posedge iCLK); #1;
        iRST_N = 1'b1;
        model_clear();
        iBLANK_LZ = 1'b0;
        tick();
        checks++; if (oDIG_SEL !== 4'b1110) begin failures++; $display("[TB] FAIL midrst_first_sel got=%b exp=1110", oDIG_SEL); end
        checks++; if (oSEG !== 7'b1000000) begin failures++; $display("[TB] FAIL midrst_first_seg got=%b exp=1000000", oSEG); end
        for (int i = 1; i < 2 * F; i++) begin
            tick();
            checks++; if (oSEG !== exp_seg) begin failures++; $display("[TB] FAIL midrst_seg_scan n=%0d got=%b exp=%b", n, oSEG, exp_seg); end
            checks++; if (oSEG_DP !== exp_dp) begin failures++; $display("[TB] FAIL midrst_dp_scan n=%0d got=%b exp=%b", n, oSEG_DP, exp_dp); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_scan();
        test_load_mid();
        test_blank_lz();
        test_boundary_load();
        test_dp();
        test_blink();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
